// File: rtl/sd_desc_fetch.sv
// Storage-descriptor fetch engine: reads entries back-to-back, decodes option pairs, presents a flat descriptor.
// Optional macro SD_DESC_FETCH_ERR_EN adds sdf__xx2__err (bad delineation or no EOM within MAX_ENTRIES).
`ifndef MGR_WU_ADDRESS_WIDTH
`define MGR_WU_ADDRESS_WIDTH 8
`endif
`ifndef MGR_WU_OPT_PER_INST
`define MGR_WU_OPT_PER_INST 4
`endif
`ifndef MGR_WU_OPT_TYPE_WIDTH
`define MGR_WU_OPT_TYPE_WIDTH 4
`endif
`ifndef MGR_WU_OPT_VALUE_WIDTH
`define MGR_WU_OPT_VALUE_WIDTH 16
`endif
`ifndef MGR_INST_TYPE_WIDTH
`define MGR_INST_TYPE_WIDTH 4
`endif

module sd_desc_fetch #(
  parameter int ADDR_W      = `MGR_WU_ADDRESS_WIDTH,
  parameter int NUM_OPT     = `MGR_WU_OPT_PER_INST,
  parameter int TYPE_W      = `MGR_WU_OPT_TYPE_WIDTH,
  parameter int VALUE_W     = `MGR_WU_OPT_VALUE_WIDTH,
  parameter int MAX_ENTRIES = 8,
  parameter logic [TYPE_W-1:0] OPT_START_ADDR = TYPE_W'(1),
  parameter logic [TYPE_W-1:0] OPT_NUM_LINES  = TYPE_W'(2),
  parameter logic [TYPE_W-1:0] OPT_STRIDE     = TYPE_W'(3),
  parameter logic [TYPE_W-1:0] OPT_ORDER      = TYPE_W'(4)
) (
  input  logic                            clk,
  input  logic                            reset_poweron,
  input  logic                            xx1__sdf__valid,
  input  logic [ADDR_W-1:0]               xx1__sdf__stor_desc_ptr,
  output logic                            sdf__xx1__ready,
  output logic                            sdf__sdm__read,
  output logic [ADDR_W-1:0]               sdf__sdm__addr,
  input  logic                            sdm__sdf__valid,
  input  logic [1:0]                      sdm__sdf__icntl,
  input  logic [1:0]                      sdm__sdf__dcntl,
  input  logic [`MGR_INST_TYPE_WIDTH-1:0] sdm__sdf__op,
  input  logic [TYPE_W-1:0]               sdm__sdf__option_type  [NUM_OPT],
  input  logic [VALUE_W-1:0]              sdm__sdf__option_value [NUM_OPT],
  output logic                            sdf__xx2__valid,
  input  logic                            xx2__sdf__ready,
  output logic [VALUE_W-1:0]              sdf__xx2__start_addr,
  output logic [VALUE_W-1:0]              sdf__xx2__num_lines,
  output logic [VALUE_W-1:0]              sdf__xx2__stride,
  output logic [VALUE_W-1:0]              sdf__xx2__order,
  output logic [3:0]                      sdf__xx2__num_entries
`ifdef SD_DESC_FETCH_ERR_EN
  ,
  output logic                            sdf__xx2__err
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_HOLD} state_t;
  localparam logic [3:0] MAX_CNT = 4'(MAX_ENTRIES);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [3:0]          issued_q, issued_d, entries_q, entries_d;
  logic [2:0]          out_q, out_d;
  logic                done_q, done_d, rdy_q, rdy_d, vld_q, vld_d;
  logic [VALUE_W-1:0]  start_q, start_d, lines_q, lines_d, stride_q, stride_d, order_q, order_d;
  logic                read, ret_live, take, ret_eom;
`ifdef SD_DESC_FETCH_ERR_EN
  logic                err_q, err_d;
`endif

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    issued_d  = issued_q;
    entries_d = entries_q;
    out_d     = out_q;
    done_d    = done_q;
    start_d   = start_q;
    lines_d   = lines_q;
    stride_d  = stride_q;
    order_d   = order_q;
`ifdef SD_DESC_FETCH_ERR_EN
    err_d     = err_q;
`endif
    read      = 1'b0;
    // Only a live fetch owns the return path; anything arriving in IDLE is stale.
    ret_live  = sdm__sdf__valid && (state_q == S_ISSUE || state_q == S_DRAIN);
    take      = ret_live && !done_q;
    ret_eom   = take && sdm__sdf__dcntl[0];

    case (state_q)
      S_IDLE: begin
        if (xx1__sdf__valid) begin
          state_d   = S_ISSUE;
          addr_d    = xx1__sdf__stor_desc_ptr;
          issued_d  = '0;
          entries_d = '0;
          out_d     = '0;
          done_d    = 1'b0;
          start_d   = '0;
          lines_d   = '0;
          stride_d  = '0;
          order_d   = '0;
`ifdef SD_DESC_FETCH_ERR_EN
          err_d     = 1'b0;
`endif
        end
      end
      S_ISSUE: begin
        read = !ret_eom && (issued_q < MAX_CNT);
        if (read) begin
          addr_d   = addr_q + ADDR_W'(1);
          issued_d = issued_q + 4'd1;
        end
        if (ret_eom || issued_d == MAX_CNT) state_d = S_DRAIN;
      end
      S_HOLD: begin
        if (xx2__sdf__ready) state_d = S_IDLE;
      end
      default: ;
    endcase

    if (take) begin
      entries_d = entries_q + 4'd1;
      for (int i = 0; i < NUM_OPT; i++) begin
        case (sdm__sdf__option_type[i])
          OPT_START_ADDR: start_d  = sdm__sdf__option_value[i];
          OPT_NUM_LINES:  lines_d  = sdm__sdf__option_value[i];
          OPT_STRIDE:     stride_d = sdm__sdf__option_value[i];
          OPT_ORDER:      order_d  = sdm__sdf__option_value[i];
          default: ;
        endcase
      end
      if (sdm__sdf__dcntl[0]) done_d = 1'b1;
`ifdef SD_DESC_FETCH_ERR_EN
      if ((entries_q == 4'd0) != sdm__sdf__icntl[1]) err_d = 1'b1;
      if (entries_d == MAX_CNT && !sdm__sdf__dcntl[0]) err_d = 1'b1;
`endif
    end

    case ({read, ret_live})
      2'b10:   out_d = out_q + 3'd1;
      2'b01:   out_d = out_q - 3'd1;
      default: ;
    endcase

    // Counting the return in the same cycle lets HOLD start right after the last return.
    if (state_q == S_DRAIN && out_d == 3'd0) state_d = S_HOLD;

    rdy_d = (state_d == S_IDLE);
    vld_d = (state_d == S_HOLD);
  end

  always_ff @(posedge clk or negedge reset_poweron) begin
    if (!reset_poweron) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      issued_q  <= '0;
      entries_q <= '0;
      out_q     <= '0;
      done_q    <= 1'b0;
      rdy_q     <= 1'b0;
      vld_q     <= 1'b0;
      start_q   <= '0;
      lines_q   <= '0;
      stride_q  <= '0;
      order_q   <= '0;
`ifdef SD_DESC_FETCH_ERR_EN
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      issued_q  <= issued_d;
      entries_q <= entries_d;
      out_q     <= out_d;
      done_q    <= done_d;
      rdy_q     <= rdy_d;
      vld_q     <= vld_d;
      start_q   <= start_d;
      lines_q   <= lines_d;
      stride_q  <= stride_d;
      order_q   <= order_d;
`ifdef SD_DESC_FETCH_ERR_EN
      err_q     <= err_d;
`endif
    end
  end

  assign sdf__xx1__ready       = rdy_q;
  assign sdf__sdm__read        = read;
  assign sdf__sdm__addr        = addr_q;
  assign sdf__xx2__valid       = vld_q;
  assign sdf__xx2__start_addr  = start_q;
  assign sdf__xx2__num_lines   = lines_q;
  assign sdf__xx2__stride      = stride_q;
  assign sdf__xx2__order       = order_q;
  assign sdf__xx2__num_entries = entries_q;
`ifdef SD_DESC_FETCH_ERR_EN
  assign sdf__xx2__err         = err_q;
`endif

  logic unused_in;
  assign unused_in = ^{sdm__sdf__op, sdm__sdf__icntl, sdm__sdf__dcntl[1]};

endmodule

// File: tb/tb_sd_desc_fetch.sv
// Bench for sd_desc_fetch: fixed-latency descriptor memory responder plus an entry-walking reference model.
`ifndef MGR_WU_ADDRESS_WIDTH
`define MGR_WU_ADDRESS_WIDTH 8
`endif
`ifndef MGR_WU_OPT_PER_INST
`define MGR_WU_OPT_PER_INST 4
`endif
`ifndef MGR_WU_OPT_TYPE_WIDTH
`define MGR_WU_OPT_TYPE_WIDTH 4
`endif
`ifndef MGR_WU_OPT_VALUE_WIDTH
`define MGR_WU_OPT_VALUE_WIDTH 16
`endif
`ifndef MGR_INST_TYPE_WIDTH
`define MGR_INST_TYPE_WIDTH 4
`endif

module tb_sd_desc_fetch;
  localparam int ADDR_W  = `MGR_WU_ADDRESS_WIDTH;
  localparam int NUM_OPT = `MGR_WU_OPT_PER_INST;
  localparam int TYPE_W  = `MGR_WU_OPT_TYPE_WIDTH;
  localparam int VALUE_W = `MGR_WU_OPT_VALUE_WIDTH;
  localparam int OP_W    = `MGR_INST_TYPE_WIDTH;
  localparam int MAXE    = 8;
  localparam int MEM     = 1 << ADDR_W;

  logic                clk, reset_poweron;
  logic                xx1__sdf__valid, sdf__xx1__ready;
  logic [ADDR_W-1:0]   xx1__sdf__stor_desc_ptr;
  logic                sdf__sdm__read;
  logic [ADDR_W-1:0]   sdf__sdm__addr;
  logic                sdm__sdf__valid;
  logic [1:0]          sdm__sdf__icntl, sdm__sdf__dcntl;
  logic [OP_W-1:0]     sdm__sdf__op;
  logic [TYPE_W-1:0]   sdm__sdf__option_type  [NUM_OPT];
  logic [VALUE_W-1:0]  sdm__sdf__option_value [NUM_OPT];
  logic                sdf__xx2__valid, xx2__sdf__ready;
  logic [VALUE_W-1:0]  sdf__xx2__start_addr, sdf__xx2__num_lines, sdf__xx2__stride, sdf__xx2__order;
  logic [3:0]          sdf__xx2__num_entries;
`ifdef SD_DESC_FETCH_ERR_EN
  logic                sdf__xx2__err;
`endif

  sd_desc_fetch dut (
    .clk                     (clk),
    .reset_poweron           (reset_poweron),
    .xx1__sdf__valid         (xx1__sdf__valid),
    .xx1__sdf__stor_desc_ptr (xx1__sdf__stor_desc_ptr),
    .sdf__xx1__ready         (sdf__xx1__ready),
    .sdf__sdm__read          (sdf__sdm__read),
    .sdf__sdm__addr          (sdf__sdm__addr),
    .sdm__sdf__valid         (sdm__sdf__valid),
    .sdm__sdf__icntl         (sdm__sdf__icntl),
    .sdm__sdf__dcntl         (sdm__sdf__dcntl),
    .sdm__sdf__op            (sdm__sdf__op),
    .sdm__sdf__option_type   (sdm__sdf__option_type),
    .sdm__sdf__option_value  (sdm__sdf__option_value),
    .sdf__xx2__valid         (sdf__xx2__valid),
    .xx2__sdf__ready         (xx2__sdf__ready),
    .sdf__xx2__start_addr    (sdf__xx2__start_addr),
    .sdf__xx2__num_lines     (sdf__xx2__num_lines),
    .sdf__xx2__stride        (sdf__xx2__stride),
    .sdf__xx2__order         (sdf__xx2__order),
    .sdf__xx2__num_entries   (sdf__xx2__num_entries)
`ifdef SD_DESC_FETCH_ERR_EN
    ,
    .sdf__xx2__err           (sdf__xx2__err)
`endif
  );

  // Descriptor memory image
  logic [1:0]         m_icntl [MEM];
  logic [1:0]         m_dcntl [MEM];
  logic [TYPE_W-1:0]  m_type  [MEM][NUM_OPT];
  logic [VALUE_W-1:0] m_val   [MEM][NUM_OPT];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [ADDR_W-1:0] rd_log [$];

  logic [VALUE_W-1:0] exp_start, exp_lines, exp_stride, exp_order;
  int   exp_ent, exp_reads, exp_lat;
  logic exp_err;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // Memory responder: a read seen in cycle t is returned during cycle t+2.
  logic              p0_v = 1'b0, p1_v = 1'b0;
  logic [ADDR_W-1:0] p0_a = '0,   p1_a = '0;
  initial begin
    sdm__sdf__valid = 1'b0;
    sdm__sdf__icntl = 2'b00;
    sdm__sdf__dcntl = 2'b00;
    sdm__sdf__op    = '0;
    for (int s = 0; s < NUM_OPT; s++) begin
      sdm__sdf__option_type[s]  = '0;
      sdm__sdf__option_value[s] = '0;
    end
    forever begin
      @(posedge clk);
      #1;
      sdm__sdf__valid = p1_v;
      if (p1_v) begin
        sdm__sdf__icntl = m_icntl[p1_a];
        sdm__sdf__dcntl = m_dcntl[p1_a];
        sdm__sdf__op    = OP_W'($urandom);
        for (int s = 0; s < NUM_OPT; s++) begin
          sdm__sdf__option_type[s]  = m_type[p1_a][s];
          sdm__sdf__option_value[s] = m_val[p1_a][s];
        end
      end
      p1_v = p0_v;
      p1_a = p0_a;
      @(negedge clk);
      p0_v = sdf__sdm__read;
      p0_a = sdf__sdm__addr;
      if (sdf__sdm__read === 1'b1) rd_log.push_back(sdf__sdm__addr);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_entry(input logic [ADDR_W-1:0] a, input logic [1:0] ic, input logic [1:0] dc);
    m_icntl[a] = ic;
    m_dcntl[a] = dc;
    for (int s = 0; s < NUM_OPT; s++) begin
      m_type[a][s] = '0;
      m_val[a][s]  = VALUE_W'($urandom);
    end
  endtask

  // len 1..8 places EOM on entry len; len 9 means no EOM within MAXE entries.
  task automatic gen_desc(input logic [ADDR_W-1:0] ptr, input int len, input bit bad);
    int n = (len > MAXE) ? MAXE : len;
    int bad_e = $urandom_range(0, n - 1);
    for (int e = 0; e < n; e++) begin
      logic [ADDR_W-1:0] a = ptr + ADDR_W'(e);
      logic [1:0] ic = (e == 0) ? ((len == 1) ? 2'b11 : 2'b10) : ((e == len - 1) ? 2'b01 : 2'b00);
      if (bad && e == bad_e) ic = (e == 0) ? 2'b00 : 2'b10;
      m_icntl[a] = ic;
      m_dcntl[a] = {1'($urandom), (e == len - 1)};
      for (int s = 0; s < NUM_OPT; s++) begin
        m_type[a][s] = TYPE_W'($urandom_range(0, 6));
        m_val[a][s]  = VALUE_W'($urandom);
      end
    end
  endtask

  // Walk the descriptor as the memory holds it and derive the expected result.
  task automatic model(input logic [ADDR_W-1:0] ptr);
    bit eom = 0;
    exp_start = '0; exp_lines = '0; exp_stride = '0; exp_order = '0;
    exp_ent = 0; exp_err = 1'b0;
    for (int e = 0; e < MAXE; e++) begin
      logic [ADDR_W-1:0] a = ptr + ADDR_W'(e);
      exp_ent = e + 1;
      if (e == 0 && !(m_icntl[a] == 2'b10 || m_icntl[a] == 2'b11)) exp_err = 1'b1;
      if (e > 0 && m_icntl[a] == 2'b10) exp_err = 1'b1;
      for (int s = 0; s < NUM_OPT; s++) begin
        if (m_type[a][s] == 1) exp_start  = m_val[a][s];
        if (m_type[a][s] == 2) exp_lines  = m_val[a][s];
        if (m_type[a][s] == 3) exp_stride = m_val[a][s];
        if (m_type[a][s] == 4) exp_order  = m_val[a][s];
      end
      if (m_dcntl[a][0]) begin
        eom = 1;
        break;
      end
    end
    if (!eom) exp_err = 1'b1;
    exp_reads = (eom && exp_ent < MAXE) ? exp_ent + 1 : MAXE;
    exp_lat   = (eom && exp_ent < MAXE) ? exp_ent + 4 : -1;
  endtask

  // Called at the +1 phase of an IDLE cycle; returns at the +1 phase of the next IDLE cycle.
  task automatic do_fetch(input string tag, input logic [ADDR_W-1:0] ptr, input int hold);
    int waited, t0;
    bit stable, addr_ok;
    logic [VALUE_W-1:0] s0, s1, s2, s3;
    logic [3:0] sn;
    model(ptr);
    rd_log.delete();
    xx1__sdf__valid = 1'b1;
    xx1__sdf__stor_desc_ptr = ptr;
    waited = 0;
    @(negedge clk);
    while (sdf__xx1__ready !== 1'b1 && waited < 20) begin
      step(); @(negedge clk); waited++;
    end
    chk({tag, "_accept"}, 32'(sdf__xx1__ready), 32'd1);
    t0 = cyc;
    step();
    xx1__sdf__valid = 1'b0;
    xx1__sdf__stor_desc_ptr = ADDR_W'($urandom);
    waited = 0;
    @(negedge clk);
    while (sdf__xx2__valid !== 1'b1 && waited < 40) begin
      step(); @(negedge clk); waited++;
    end
    chk({tag, "_out_vld"}, 32'(sdf__xx2__valid), 32'd1);
    if (exp_lat >= 0) chk({tag, "_latency"}, 32'(cyc - t0), 32'(exp_lat));
    chk({tag, "_start"},  32'(sdf__xx2__start_addr), 32'(exp_start));
    chk({tag, "_lines"},  32'(sdf__xx2__num_lines),  32'(exp_lines));
    chk({tag, "_stride"}, 32'(sdf__xx2__stride),     32'(exp_stride));
    chk({tag, "_order"},  32'(sdf__xx2__order),      32'(exp_order));
    chk({tag, "_entries"}, 32'(sdf__xx2__num_entries), 32'(exp_ent));
`ifdef SD_DESC_FETCH_ERR_EN
    chk({tag, "_err"}, 32'(sdf__xx2__err), 32'(exp_err));
`endif
    chk({tag, "_nreads"}, 32'(rd_log.size()), 32'(exp_reads));
    addr_ok = 1;
    foreach (rd_log[i]) if (rd_log[i] !== ptr + ADDR_W'(i)) addr_ok = 0;
    chk({tag, "_read_addrs"}, 32'(addr_ok), 32'd1);
    s0 = sdf__xx2__start_addr; s1 = sdf__xx2__num_lines;
    s2 = sdf__xx2__stride;     s3 = sdf__xx2__order;
    sn = sdf__xx2__num_entries;
    stable = 1;
    for (int i = 0; i < hold; i++) begin
      step(); @(negedge clk);
      if (sdf__xx2__valid !== 1'b1 || sdf__xx2__start_addr !== s0 || sdf__xx2__num_lines !== s1 ||
          sdf__xx2__stride !== s2 || sdf__xx2__order !== s3 || sdf__xx2__num_entries !== sn ||
          sdf__sdm__read !== 1'b0) stable = 0;
    end
    if (hold > 0) chk({tag, "_hold_stable"}, 32'(stable), 32'd1);
    step();
    xx2__sdf__ready = 1'b1;
    @(negedge clk);
    chk({tag, "_hs_vld_rdy"}, {30'd0, sdf__xx2__valid, sdf__xx1__ready}, 32'h2);
    step();
    xx2__sdf__ready = 1'b0;
    @(negedge clk);
    chk({tag, "_idle_vld_rdy"}, {30'd0, sdf__xx2__valid, sdf__xx1__ready}, 32'h1);
    step();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"}, 32'(sdf__xx1__ready), 32'd0);
    chk({tag, "_read"},  32'(sdf__sdm__read),  32'd0);
    chk({tag, "_addr"},  32'(sdf__sdm__addr),  32'd0);
    chk({tag, "_vld"},   32'(sdf__xx2__valid), 32'd0);
    chk({tag, "_fields"}, 32'({sdf__xx2__start_addr | sdf__xx2__num_lines | sdf__xx2__stride | sdf__xx2__order}), 32'd0);
    chk({tag, "_entries"}, 32'(sdf__xx2__num_entries), 32'd0);
`ifdef SD_DESC_FETCH_ERR_EN
    chk({tag, "_err"}, 32'(sdf__xx2__err), 32'd0);
`endif
  endtask

  initial begin
    reset_poweron = 1'b0;
    xx1__sdf__valid = 1'b0;
    xx1__sdf__stor_desc_ptr = '0;
    xx2__sdf__ready = 1'b0;
    for (int a = 0; a < MEM; a++) begin
      m_icntl[a] = 2'($urandom);
      m_dcntl[a] = 2'($urandom);
      for (int s = 0; s < NUM_OPT; s++) begin
        m_type[a][s] = TYPE_W'($urandom_range(0, 6));
        m_val[a][s]  = VALUE_W'($urandom);
      end
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_vals("por");
    reset_poweron = 1'b1;
    step(); step();
    @(negedge clk);
    chk("por_ready_after", 32'(sdf__xx1__ready), 32'd1);
    step();

    // One SOM_EOM entry at 0x10
    set_entry(8'h10, 2'b11, 2'b01);
    m_type[8'h10][0] = 1; m_val[8'h10][0] = 16'h0400;
    m_type[8'h10][1] = 2; m_val[8'h10][1] = 16'h0008;
    do_fetch("single", 8'h10, 0);

    // SOM/MOM/EOM at 0x20 with downstream stalled for 10 cycles
    set_entry(8'h20, 2'b10, 2'b00);
    set_entry(8'h21, 2'b00, 2'b00);
    m_type[8'h21][2] = 3; m_val[8'h21][2] = 16'h0040;
    set_entry(8'h22, 2'b01, 2'b01);
    m_type[8'h22][3] = 4; m_val[8'h22][3] = 16'h0001;
    do_fetch("three", 8'h20, 10);

    // Back-to-back request straight after the handshake; no EOM within 8
    for (int e = 0; e < MAXE; e++) begin
      set_entry(8'h40 + 8'(e), (e == 0) ? 2'b10 : 2'b00, 2'b00);
      m_type[8'h40 + 8'(e)][e % NUM_OPT] = TYPE_W'(1 + (e % 4));
    end
    do_fetch("no_eom", 8'h40, 0);

    // Address wrap
    set_entry(8'hFF, 2'b10, 2'b00);
    m_type[8'hFF][0] = 1; m_val[8'hFF][0] = 16'h1234;
    set_entry(8'h00, 2'b01, 2'b01);
    m_type[8'h00][1] = 1; m_val[8'h00][1] = 16'h5678;
    do_fetch("wrap", 8'hFF, 0);

    // Reset with two reads in flight
    gen_desc(8'h30, 3, 0);
    xx1__sdf__valid = 1'b1;
    xx1__sdf__stor_desc_ptr = 8'h30;
    @(negedge clk);
    chk("mid_rst_accept", 32'(sdf__xx1__ready), 32'd1);
    step();
    xx1__sdf__valid = 1'b0;
    step();
    step();
    reset_poweron = 1'b0;
    #1;
    chk_reset_vals("mid_rst");
    @(negedge clk);
    reset_poweron = 1'b1;
    step(); step(); step();
    @(negedge clk);
    chk("post_rst_ready", 32'(sdf__xx1__ready), 32'd1);
    chk("post_rst_state", {16'd0, sdf__sdm__addr, 3'd0, sdf__sdm__read, sdf__xx2__num_entries}, 32'd0);
    chk("post_rst_vld", 32'(sdf__xx2__valid), 32'd0);
    step();
    gen_desc(8'h30, 2, 0);
    do_fetch("after_rst", 8'h30, 0);

    // Randomised descriptors
    for (int r = 0; r < 12; r++) begin
      logic [ADDR_W-1:0] p = ADDR_W'($urandom);
      gen_desc(p, $urandom_range(1, 9), ($urandom_range(0, 3) == 0));
      do_fetch($sformatf("rnd%0d", r), p, $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sd_desc_fetch.md
# sd_desc_fetch

Storage-descriptor fetch engine in the manager: the requesting end of the storage-descriptor memory read interface. It accepts a descriptor pointer from WU decode and issues back-to-back reads to the descriptor memory. It collects the returned entries, which are delineated by icntl/dcntl, until end-of-descriptor. It decodes the option type/value pairs into a flat descriptor and presents it downstream with a valid/ready handshake.

## Interface
Parameters:
- ADDR_W, `MGR_WU_ADDRESS_WIDTH, descriptor memory address width
- NUM_OPT, `MGR_WU_OPT_PER_INST, option slots per entry
- TYPE_W, `MGR_WU_OPT_TYPE_WIDTH, option type width
- VALUE_W, `MGR_WU_OPT_VALUE_WIDTH, option value width
- MAX_ENTRIES, 8, maximum entries read per descriptor
- OPT_START_ADDR / OPT_NUM_LINES / OPT_STRIDE / OPT_ORDER, 1/2/3/4, recognised option type codes

Ports:
- clk  in  1  clock, all logic on rising edge
- reset_poweron  in  1  reset; asynchronous, active-low
- xx1__sdf__valid  in  1  fetch request
- xx1__sdf__stor_desc_ptr  in  ADDR_W  first entry address
- sdf__xx1__ready  out  1  request accepted when valid&ready
- sdf__sdm__read  out  1  read strobe to descriptor memory
- sdf__sdm__addr  out  ADDR_W  read address
- sdm__sdf__valid  in  1  returned entry valid
- sdm__sdf__icntl, sdm__sdf__dcntl  in  2 each  delineators
- sdm__sdf__op  in  `MGR_INST_TYPE_WIDTH  entry op (ignored)
- sdm__sdf__option_type[NUM_OPT]  in  TYPE_W  option types
- sdm__sdf__option_value[NUM_OPT]  in  VALUE_W  option values
- sdf__xx2__valid  out  1  descriptor available
- xx2__sdf__ready  in  1  downstream accept
- sdf__xx2__start_addr, __num_lines, __stride, __order  out  VALUE_W each  decoded fields
- sdf__xx2__num_entries  out  4  entries consumed, including the EOM entry

## Operation
- Delineator encoding: SOM=2'b10, MOM=2'b00, EOM=2'b01, SOM_EOM=2'b11. dcntl bit0 set means last entry.
- The FSM has four states: IDLE, ISSUE, DRAIN, HOLD.
- IDLE: ready=1. On valid, capture ptr into addr, clear fields, issued and entries, then go to ISSUE.
- ISSUE:
  - read = !(ret_eom) && issued<MAX_ENTRIES, where ret_eom = sdm valid & dcntl bit0 & !done.
  - Each read increments addr (mod 2^ADDR_W) and issued.
  - On ret_eom, or when issued reaches MAX_ENTRIES, go to DRAIN.
- Returned entries accepted while !done: entries++. For each slot 0..NUM_OPT-1 in order, a recognised type loads the matching field. Later slots and later entries overwrite earlier ones; unrecognised types are ignored. The EOM entry sets done.
- Returns after done are discarded.
- An outstanding counter (3 bits) increments per read and decrements per return. DRAIN waits for outstanding==0, then goes to HOLD.
- HOLD: sdf__xx2__valid=1 with fields stable. On xx2__sdf__ready, go to IDLE.
- MAX_ENTRIES reached without EOM: the descriptor is still emitted with the fields collected so far.

## Timing
- Descriptor memory latency is fixed: a read at cycle t returns at t+2.
- Reads issue every cycle in ISSUE. Overshoot past EOM is at most 1 read, and that return is discarded.
- Request accept at t0 gives the first read at t0+1. For an N-entry descriptor, sdf__xx2__valid rises at t0+N+4 with no stall.
- Reset values: ready=0 during reset, 1 after (IDLE). read=0, addr=0, xx2 valid=0, all fields=0, num_entries=0, outstanding=0.
- Reset asserted mid-fetch returns everything to the reset values immediately. Stale sdm returns arriving after reset release in IDLE are ignored.
- A new request is accepted only in IDLE. The cycle of the HOLD handshake is not also an accept cycle.

## Configuration
- SD_DESC_FETCH_ERR_EN defined:
  - Adds output sdf__xx2__err (1 bit, reset 0, valid with sdf__xx2__valid).
  - err is set if the first accepted entry's icntl is not SOM or SOM_EOM, if a later entry carries SOM, or if MAX_ENTRIES is reached without EOM.
  - err is cleared on leaving IDLE.
- SD_DESC_FETCH_ERR_EN undefined: the err port is absent, no checking is done, and behaviour is otherwise identical.

## Test plan
- Single SOM_EOM entry at ptr 0x10 with slot0 type1=0x400 and slot1 type2=0x8:
  - Required reads: 0x10 and 0x11 only.
  - Required output: start_addr=0x400, num_lines=8, num_entries=1, valid at t0+5.
- Three entries SOM/MOM/EOM at 0x20 with stride 0x40 in entry 1 and order 1 in entry 2:
  - Required output: stride=0x40, order=1, num_entries=3.
  - Exactly 4 reads issued, and the 4th return is discarded.
- xx2__sdf__ready held low 10 cycles: valid and fields stay stable. Ready pulse gives IDLE next cycle, and a back-to-back request is then accepted.
- No EOM within 8 entries: 8 reads issued, num_entries=8, err=1 with ERR_EN defined.
- ptr = 2^ADDR_W-1 with a 2-entry descriptor: the second read address wraps to 0.
- Reset asserted while ISSUE has 2 reads outstanding: outputs take their reset values at once, the late returns are ignored, and a subsequent fetch is correct.
